// File: rtl/macu_psum_drain.sv
// Column sink for the CONV MAC array: accumulates K-tile partial sums, requantises
// them to DW-bit activations and queues the results. Define MACU_DRAIN_RELU_EN for ReLU.
module macu_psum_drain #(
  parameter int DW         = 8,
  parameter int ADDW       = 10,
  parameter int ACCW       = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [ADDW:0] psum_in,
  input  logic          psum_vld,
  input  logic          tile_last,
  input  logic [4:0]    shift,
  output logic [DW-1:0] out_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic          almost_full,
  output logic          ovf_err,
  output logic          drop_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};
  localparam logic signed [ACCW:0]   Q_MAX   = (ACCW+1)'(2**(DW-1) - 1);
  localparam logic signed [ACCW:0]   Q_MIN   = (ACCW+1)'(-(2**(DW-1)));
  localparam logic [4:0]             SH_MAX  = 5'(ACCW - 1);

  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t                 state;
  logic signed [ACCW-1:0] acc;
  logic                   rq_vld;
  logic [DW-1:0]          rq_data;

  logic signed [ACCW-1:0] acc_eff;
  logic signed [ACCW:0]   psum_ext;
  logic signed [ACCW:0]   sum_wide;
  logic signed [ACCW-1:0] sum_sat;
  logic                   sum_ovf;

  logic [4:0]             rq_sh;
  logic signed [ACCW:0]   rnd;
  logic signed [ACCW:0]   rounded;
  logic signed [ACCW:0]   shifted;
  logic signed [ACCW:0]   relu_val;
  logic signed [ACCW:0]   q_val;

  logic [DW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            count;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Accumulate one extra bit wide so that saturation can be detected from the top two bits.
  always_comb begin
    acc_eff  = (state == S_ACC) ? acc : '0;
    psum_ext = {{(ACCW-ADDW){psum_in[ADDW]}}, psum_in};
    sum_wide = {acc_eff[ACCW-1], acc_eff} + psum_ext;
    sum_ovf  = sum_wide[ACCW] != sum_wide[ACCW-1];
    if (!sum_ovf)
      sum_sat = ACCW'(sum_wide);
    else if (sum_wide[ACCW])
      sum_sat = ACC_MIN;
    else
      sum_sat = ACC_MAX;
  end

  // Round half up, arithmetic shift, optional ReLU, then clamp to the DW-bit signed range.
  always_comb begin
    rq_sh   = (shift > SH_MAX) ? SH_MAX : shift;
    rnd     = '0;
    if (rq_sh != 5'd0)
      rnd = (ACCW+1)'(1) <<< (rq_sh - 5'd1);
    rounded = {sum_sat[ACCW-1], sum_sat} + rnd;
    shifted = rounded >>> rq_sh;
`ifdef MACU_DRAIN_RELU_EN
    relu_val = shifted[ACCW] ? '0 : shifted;
`else
    relu_val = shifted;
`endif
    if (relu_val > Q_MAX)
      q_val = Q_MAX;
    else if (relu_val < Q_MIN)
      q_val = Q_MIN;
    else
      q_val = relu_val;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state   <= S_IDLE;
      acc     <= '0;
      rq_vld  <= 1'b0;
      rq_data <= '0;
      ovf_err <= 1'b0;
    end else begin
      rq_vld <= 1'b0;
      if (psum_vld) begin
        if (sum_ovf)
          ovf_err <= 1'b1;
        if (tile_last) begin
          acc     <= '0;
          state   <= S_IDLE;
          rq_vld  <= 1'b1;
          rq_data <= DW'(q_val);
        end else begin
          acc   <= sum_sat;
          state <= S_ACC;
        end
      end
    end
  end

  // A push on a full FIFO only succeeds when the head leaves in the same cycle.
  always_comb begin
    full = (count == (AW+1)'(FIFO_DEPTH));
    pop  = out_vld && out_rdy;
    push = rq_vld && (!full || pop);
    drop = rq_vld && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop)
        drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rq_data;
  end

  always_comb begin
    out_vld     = (count != '0);
    out_data    = out_vld ? mem[rd_ptr] : '0;
    almost_full = (count >= (AW+1)'(FIFO_DEPTH - 2));
  end

endmodule

// File: tb/tb_macu_psum_drain.sv
// Directed table-driven bench for macu_psum_drain, plus hand-written multi-cycle sequences.
module tb_macu_psum_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [10:0] psum_in;
  logic        psum_vld;
  logic        tile_last;
  logic [4:0]  shift;
  logic [7:0]  out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        almost_full;
  logic        ovf_err;
  logic        drop_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int psum;
    int sh;
    int expv;
  } vec_t;

  vec_t tbl[12];

  macu_psum_drain dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .psum_in     (psum_in),
    .psum_vld    (psum_vld),
    .tile_last   (tile_last),
    .shift       (shift),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .almost_full (almost_full),
    .ovf_err     (ovf_err),
    .drop_err    (drop_err)
  );

  always #5 clk = ~clk;

  // Expected value after the optional ReLU build option.
  function automatic int relu(input int v);
`ifdef MACU_DRAIN_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One valid psum beat, presented for exactly one rising edge.
  task automatic applyStimulus(input int p, input logic last, input int sh);
    @(negedge clk);
    psum_in   = 11'(p);
    psum_vld  = 1'b1;
    tile_last = last;
    shift     = 5'(sh);
    @(negedge clk);
    psum_vld  = 1'b0;
    tile_last = 1'b0;
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  initial begin
    tbl[0]  = '{psum: 100,   sh: 0, expv: 100};
    tbl[1]  = '{psum: 100,   sh: 2, expv: 25};
    tbl[2]  = '{psum: 300,   sh: 0, expv: 127};
    tbl[3]  = '{psum: -300,  sh: 0, expv: relu(-128)};
    tbl[4]  = '{psum: -5,    sh: 1, expv: relu(-2)};
    tbl[5]  = '{psum: 254,   sh: 1, expv: 127};
    tbl[6]  = '{psum: 255,   sh: 1, expv: 127};
    tbl[7]  = '{psum: -257,  sh: 1, expv: relu(-128)};
    tbl[8]  = '{psum: -259,  sh: 1, expv: relu(-128)};
    tbl[9]  = '{psum: 1023,  sh: 3, expv: 127};
    tbl[10] = '{psum: -1024, sh: 4, expv: relu(-64)};
    tbl[11] = '{psum: 0,     sh: 0, expv: 0};

    rst_n = 1'b0; clr = 1'b0; psum_in = '0; psum_vld = 1'b0;
    tile_last = 1'b0; shift = '0; out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset out_vld", int'(out_vld), 0);
    checkOutput("reset out_data", int'(out_data), 0);
    checkOutput("reset almost_full", int'(almost_full), 0);
    checkOutput("reset ovf_err", int'(ovf_err), 0);
    checkOutput("reset drop_err", int'(drop_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-tile results: not visible one cycle after tile_last, visible the next.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].psum, 1'b1, tbl[i].sh);
      checkOutput($sformatf("vec%0d latency", i), int'(out_vld), 0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d out_vld", i), int'(out_vld), 1);
      checkOutput($sformatf("vec%0d out_data", i), sdata(), tbl[i].expv);
    end
    @(negedge clk);
    checkOutput("table drained", int'(out_vld), 0);
    checkOutput("no ovf after table", int'(ovf_err), 0);

    // Three tiles: 50 + 60 - 20 = 90, shift 1 -> 45.
    applyStimulus(50, 1'b0, 0);
    applyStimulus(60, 1'b0, 0);
    applyStimulus(-20, 1'b1, 1);
    @(negedge clk);
    checkOutput("3tile out_data", sdata(), 45);
    checkOutput("3tile out_vld", int'(out_vld), 1);
    @(negedge clk);

    // Backpressure: four entries held, fifth dropped.
    out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(10 * (i + 1), 1'b1, 0);
      @(negedge clk);
      checkOutput($sformatf("bp almost_full %0d", i), int'(almost_full), (i >= 1) ? 1 : 0);
      checkOutput($sformatf("bp drop_err %0d", i), int'(drop_err), (i == 4) ? 1 : 0);
    end
    checkOutput("bp head", sdata(), 10);
    out_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("drain vld %0d", j), int'(out_vld), 1);
      checkOutput($sformatf("drain data %0d", j), sdata(), 10 * (j + 1));
      @(negedge clk);
    end
    checkOutput("drain empty vld", int'(out_vld), 0);
    checkOutput("drain empty data", int'(out_data), 0);
    checkOutput("drop_err sticky", int'(drop_err), 1);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr drop_err", int'(drop_err), 0);

    // clr mid-accumulation discards the partial sum.
    applyStimulus(33, 1'b0, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(5, 1'b1, 0);
    @(negedge clk);
    checkOutput("clr acc discard", sdata(), 5);
    @(negedge clk);

    // Reset while holding acc=110 and a queued result.
    out_rdy = 1'b0;
    applyStimulus(9, 1'b1, 0);
    applyStimulus(50, 1'b0, 0);
    applyStimulus(60, 1'b0, 0);
    checkOutput("pre-reset queued", int'(out_vld), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst fifo empty", int'(out_vld), 0);
    checkOutput("rst out_data", int'(out_data), 0);
    checkOutput("rst almost_full", int'(almost_full), 0);
    out_rdy = 1'b1;
    applyStimulus(7, 1'b1, 0);
    @(negedge clk);
    checkOutput("post-reset out", sdata(), 7);
    @(negedge clk);

    // 600 x 1023 overflows the 20-bit accumulator.
    @(negedge clk);
    psum_in = 11'd1023; psum_vld = 1'b1; tile_last = 1'b0; shift = 5'd0;
    repeat (599) @(negedge clk);
    tile_last = 1'b1;
    @(negedge clk);
    psum_vld = 1'b0; tile_last = 1'b0;
    checkOutput("ovf_err set", int'(ovf_err), 1);
    @(negedge clk);
    checkOutput("ovf out_data", sdata(), 127);
    @(negedge clk);
    checkOutput("ovf_err sticky", int'(ovf_err), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
